exp_filter_bank: RTL and testbench

- Parametrised asymmetric exponential smoothing bank: one smoothed magnitude per spectrum bin, with separate attack (rise) and release (decay) coefficients set at run time.
- Sits between the spectrum/bin stage and the LED strip mapper.
- Adds to the earlier fixed-coefficient filter: a valid/ready input, a pipelined single-multiplier datapath with hazard forwarding, full-bank clear sequencing and an update stream output.

---
 rtl/exp_filter_pkg.sv | 13 +
 rtl/exp_filter_update.sv | 32 +++
 rtl/exp_filter_bank.sv | 89 ++++++++
 tb/tb_exp_filter_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_filter_pkg.sv
// exp_filter_pkg: shared state type and constants for the exponential filter bank
package exp_filter_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    function automatic int round_half(input int coef_w);
        return 1 << (coef_w - 1);
    endfunction

    localparam int RISE_99  = 253;
    localparam int DECAY_20 = 51;

endpackage

// File: rtl/exp_filter_update.sv
// exp_filter_update: asymmetric smoothing step, new = old + round((in-old)*alpha), saturated
module exp_filter_update
    import exp_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] in_val,
    input  logic [COEF_W-1:0] rise,
    input  logic [COEF_W-1:0] decay,
    output logic [DATA_W-1:0] new_val
);
    localparam int PW = DATA_W + COEF_W + 2;
    localparam logic signed [PW-1:0] HALF = PW'(round_half(COEF_W));

    logic [COEF_W-1:0] alpha;
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0] prod, sum, delta, nv;

    // Operands are extended to PW bits so the truncated product is the signed product
    always_comb begin
        alpha = (old_val > in_val) ? decay : rise;
        diff = $signed({1'b0, in_val}) - $signed({1'b0, old_val});
        prod = {{(PW-DATA_W-1){diff[DATA_W]}}, diff} * {{(PW-COEF_W){1'b0}}, alpha};
        sum = prod + HALF;
        delta = sum >>> COEF_W;
        nv = {{(PW-DATA_W){1'b0}}, old_val} + delta;
        new_val = nv[PW-1] ? '0 : (|nv[PW-2:DATA_W]) ? '1 : nv[DATA_W-1:0];
    end

endmodule

// File: rtl/exp_filter_bank.sv
// exp_filter_bank: per-bin asymmetric exponential smoother with 2-stage pipeline and clear sweep
module exp_filter_bank
    import exp_filter_pkg::*;
#(
    parameter int NUM_BINS = 40,
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int ADDR_W   = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0] cfg_rise,
    input  logic [COEF_W-1:0] cfg_decay,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [DATA_W-1:0] upd_data
);
    state_t state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [NUM_BINS];
    logic s1_valid, s2_valid, accept;
    logic [ADDR_W-1:0] s1_addr, s2_addr;
    logic [DATA_W-1:0] s1_data, s2_data, s1_old, s2_old, s2_new;
    logic [COEF_W-1:0] s1_rise, s1_decay, s2_rise, s2_decay;

    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign accept = in_valid && in_ready;
    // S2 writes the array at the end of this cycle, so a same-bin S1 read takes its result
    assign s1_old = (s2_valid && s2_addr == s1_addr) ? s2_new : mem[s1_addr];

    exp_filter_update #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_update (
        .old_val(s2_old),
        .in_val (s2_data),
        .rise   (s2_rise),
        .decay  (s2_decay),
        .new_val(s2_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            clr_addr <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            upd_valid <= 1'b0;
            upd_addr <= '0;
            upd_data <= '0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: if (clear) state <= DRAIN;
                DRAIN: if (!s1_valid && !s2_valid) begin
                    state <= CLEAR;
                    clr_addr <= '0;
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(NUM_BINS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            s1_valid <= accept;
            s2_valid <= s1_valid;
            upd_valid <= s2_valid;
            if (s2_valid) begin
                upd_addr <= s2_addr;
                upd_data <= s2_new;
            end
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) {s1_addr, s1_data, s1_rise, s1_decay} <= {in_addr, in_data, cfg_rise, cfg_decay};
        if (s1_valid) {s2_addr, s2_data, s2_old, s2_rise, s2_decay} <= {s1_addr, s1_data, s1_old, s1_rise, s1_decay};
        if (state == CLEAR) mem[clr_addr] <= '0;
        else if (s2_valid) mem[s2_addr] <= s2_new;
    end

endmodule

// File: tb/tb_exp_filter_bank.sv
// tb_exp_filter_bank: scoreboard bench for exp_filter_bank with defaults (40 bins, 8-bit)
module tb_exp_filter_bank;
    import exp_filter_pkg::*;

    localparam int NB = 40;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic busy;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] cfg_rise = CW'(RISE_99);
    logic [CW-1:0] cfg_decay = CW'(DECAY_20);
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic upd_valid;
    logic [AW-1:0] upd_addr;
    logic [DW-1:0] upd_data;

    typedef struct {int addr; int data;} exp_t;
    exp_t exp_q[$];
    int model[NB];
    int checks = 0;
    int errors = 0;

    exp_filter_bank #(.NUM_BINS(NB), .DATA_W(DW), .COEF_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .cfg_rise(cfg_rise), .cfg_decay(cfg_decay),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data)
    );

    always #5 clk = ~clk;

    function automatic int ref_update(input int old, input int in, input int rise, input int decay);
        int alpha, t, d, n;
        alpha = old > in ? decay : rise;
        t = (in - old) * alpha + 128;
        d = t >= 0 ? t / 256 : -((-t + 255) / 256);
        n = old + d;
        return n < 0 ? 0 : (n > 255 ? 255 : n);
    endfunction

    // Every bin write reported on the update stream is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n && upd_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected addr=%0d data=%0d expected no update", upd_addr, upd_data);
            end else begin
                e = exp_q.pop_front();
                if (upd_addr !== AW'(e.addr) || upd_data !== DW'(e.data)) begin
                    errors++;
                    $display("FAIL upd_stream got addr=%0d data=%0d expected addr=%0d data=%0d",
                             upd_addr, upd_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int a, input int d);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_addr = AW'(a);
        in_data = DW'(d);
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout bin=%0d in_ready=%b expected 1", a, in_ready);
        end else begin
            e.addr = a;
            e.data = ref_update(model[a], d, int'(cfg_rise), int'(cfg_decay));
            model[a] = e.data;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic read_bin(input int a);
        rd_addr = AW'(a);
        tick();
        checks++;
        if (rd_data !== DW'(model[a])) begin
            errors++;
            $display("FAIL read_bin%0d got %0d expected %0d", a, rd_data, model[a]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || upd_valid !== 1'b0 || rd_data !== '0 ||
            upd_addr !== '0 || upd_data !== '0) begin
            errors++;
            $display("FAIL %s busy=%b in_ready=%b upd_valid=%b rd_data=%0d upd_addr=%0d upd_data=%0d expected 1 0 0 0 0 0",
                     tag, busy, in_ready, upd_valid, rd_data, upd_addr, upd_data);
        end
    endtask

    task automatic wait_sweep(input string tag);
        int n, bad;
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) bad++;
            n++;
            tick();
        end
        checks++;
        if (n != NB || bad != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_cycles=%0d ready_during_busy=%0d in_ready_after=%b expected 40 0 1",
                     tag, n, bad, in_ready);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        wait_sweep("reset_sweep");
        for (int i = 0; i < NB; i++) read_bin(i);
    endtask

    task automatic test_rise_decay();
        send(0, 200);
        in_valid = 1'b0;
        tick();
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_latency upd_valid=%b expected 0 one cycle after accept", upd_valid);
        end
        tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_addr !== AW'(0) || upd_data !== DW'(198)) begin
            errors++;
            $display("FAIL rise_upd valid=%b addr=%0d data=%0d expected 1 0 198", upd_valid, upd_addr, upd_data);
        end
        idle(2);
        send(0, 0);
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_data !== DW'(159)) begin
            errors++;
            $display("FAIL decay_upd valid=%b data=%0d expected 1 159", upd_valid, upd_data);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        send(3, 100);
        send(3, 100);
        in_valid = 1'b0;
        tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_data !== DW'(99)) begin
            errors++;
            $display("FAIL fwd_first valid=%b data=%0d expected 1 99", upd_valid, upd_data);
        end
        tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_data !== DW'(100)) begin
            errors++;
            $display("FAIL fwd_second valid=%b data=%0d expected 1 100", upd_valid, upd_data);
        end
        idle(3);
        read_bin(3);
    endtask

    task automatic test_coef_timing();
        send(5, 200);
        cfg_rise = 8'd128;
        send(6, 200);
        in_valid = 1'b0;
        tick();
        checks++;
        if (upd_addr !== AW'(5) || upd_data !== DW'(198)) begin
            errors++;
            $display("FAIL coef_bin5 addr=%0d data=%0d expected 5 198", upd_addr, upd_data);
        end
        tick();
        checks++;
        if (upd_addr !== AW'(6) || upd_data !== DW'(100)) begin
            errors++;
            $display("FAIL coef_bin6 addr=%0d data=%0d expected 6 100", upd_addr, upd_data);
        end
        cfg_rise = CW'(RISE_99);
        idle(3);
    endtask

    task automatic test_clear();
        int n;
        send(7, 200);
        idle(4);
        read_bin(7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < NB; i++) model[i] = 0;
        in_valid = 1'b1;
        in_addr = AW'(8);
        in_data = DW'(200);
        rd_addr = AW'(7);
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != NB + 1) begin
            errors++;
            $display("FAIL clear_not_ready_cycles got %0d expected 41", n);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL clear_bin7 got %0d expected 0", rd_data);
        end
        send(8, 200);
        idle(4);
        read_bin(8);
    endtask

    task automatic test_reset_midstream();
        send(10, 200);
        send(11, 150);
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NB; i++) model[i] = 0;
        #1;
        check_reset_outputs("midreset_outputs");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs("midreset_hold");
        end
        rst_n = 1'b1;
        wait_sweep("midreset_sweep");
        idle(3);
        read_bin(10);
        read_bin(11);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) model[i] = 0;
        test_reset();
        test_rise_decay();
        test_back_to_back();
        test_coef_timing();
        test_clear();
        test_reset_midstream();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_updates got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
